noc_flit_injector: RTL and testbench

- Synthesizable NoC packet transmitter. It drives one OpenPiton-style router input port (valid/data out, yummy credit return in) on noc1/noc2/noc3.
- Accepts a packet descriptor, emits a 64-bit header flit and then `req_len` body flits. Each flit waits for a downstream buffer credit.
- Used as a traffic source at a tile or chip-edge port. The network monitor observes the opposite, router-output side of the same interface.

---
 rtl/noc_inject_pkg.sv | 48 ++++
 rtl/noc_credit_counter.sv | 37 +++
 rtl/noc_flit_injector.sv | 115 +++++++++++
 tb/tb_noc_flit_injector.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_inject_pkg.sv
// Shared definitions for the NoC flit injector: header field positions,
// FSM state encoding and the default flit width.
package noc_inject_pkg;

  localparam int FLIT_WIDTH_DEF = 64;

  localparam int HDR_CHIPID_MSB = 63;
  localparam int HDR_CHIPID_LSB = 50;
  localparam int HDR_X_MSB      = 49;
  localparam int HDR_X_LSB      = 42;
  localparam int HDR_Y_MSB      = 41;
  localparam int HDR_Y_LSB      = 34;
  localparam int HDR_FBITS_MSB  = 33;
  localparam int HDR_FBITS_LSB  = 30;
  localparam int HDR_LEN_MSB    = 29;
  localparam int HDR_LEN_LSB    = 22;
  localparam int HDR_MSG_MSB    = 21;
  localparam int HDR_MSG_LSB    = 14;
  localparam int HDR_TAG_MSB    = 13;
  localparam int HDR_TAG_LSB    = 6;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HEAD = 2'd1;
  localparam logic [1:0] ST_BODY = 2'd2;

  // Low six header bits are reserved and always zero.
  function automatic logic [63:0] build_header(
    input logic [13:0] chipid,
    input logic [7:0]  x,
    input logic [7:0]  y,
    input logic [3:0]  fbits,
    input logic [7:0]  len,
    input logic [7:0]  msg_type,
    input logic [7:0]  tag
  );
    logic [63:0] h;
    h = '0;
    h[HDR_CHIPID_MSB:HDR_CHIPID_LSB] = chipid;
    h[HDR_X_MSB:HDR_X_LSB]           = x;
    h[HDR_Y_MSB:HDR_Y_LSB]           = y;
    h[HDR_FBITS_MSB:HDR_FBITS_LSB]   = fbits;
    h[HDR_LEN_MSB:HDR_LEN_LSB]       = len;
    h[HDR_MSG_MSB:HDR_MSG_LSB]       = msg_type;
    h[HDR_TAG_MSB:HDR_TAG_LSB]       = tag;
    return h;
  endfunction

endpackage

// File: rtl/noc_credit_counter.sv
// Downstream buffer credit tracker: starts full, one credit per sent flit,
// one back per yummy, saturating at CREDITS with a sticky overflow flag.
module noc_credit_counter #(
  parameter int CREDITS = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic send,
  input  logic yummy,
  output logic avail,
  output logic ovf
);

  localparam int CW = $clog2(CREDITS + 1);
  localparam logic [CW-1:0] FULL = CW'(CREDITS);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] count;

  assign avail = (count != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= FULL;
      ovf   <= 1'b0;
    end else if (send && avail && !yummy) begin
      count <= count - ONE;
    end else if (yummy && !(send && avail)) begin
      if (count == FULL) begin
        ovf <= 1'b1;
      end else begin
        count <= count + ONE;
      end
    end
  end

endmodule

// File: rtl/noc_flit_injector.sv
// NoC packet transmitter: header plus req_len body flits, each gated by a
// downstream credit. Optional trace output under NOC_INJECT_TRACE_EN.
module noc_flit_injector
  import noc_inject_pkg::*;
#(
  parameter int FLIT_WIDTH = FLIT_WIDTH_DEF,
  parameter int CREDITS    = 4,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_val,
  output logic                  req_rdy,
  input  logic [13:0]           req_chipid,
  input  logic [7:0]            req_x,
  input  logic [7:0]            req_y,
  input  logic [3:0]            req_fbits,
  input  logic [7:0]            req_len,
  input  logic [7:0]            req_msg_type,
  input  logic [7:0]            req_tag,
  input  logic [63:0]           req_seed,
  output logic                  out_valid,
  output logic [FLIT_WIDTH-1:0] out_data,
  input  logic                  in_yummy,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  flits_sent,
  output logic                  err_credit_ovf
);

  logic [1:0]            state;
  logic [63:0]           hdr_q;
  logic [63:0]           seed_q;
  logic [7:0]            remaining_q;
  logic [7:0]            idx_q;
  logic                  avail;
  logic                  send;
  logic [FLIT_WIDTH-1:0] flit_data;

  assign req_rdy   = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign send      = ((state == ST_HEAD) || (state == ST_BODY)) && avail;
  assign flit_data = (state == ST_HEAD) ? hdr_q : (seed_q + {56'd0, idx_q});

  noc_credit_counter #(.CREDITS(CREDITS)) u_credits (
    .clk   (clk),
    .rst_n (rst_n),
    .send  (send),
    .yummy (in_yummy),
    .avail (avail),
    .ovf   (err_credit_ovf)
  );

  // out_data keeps the last flit after out_valid drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      hdr_q       <= '0;
      seed_q      <= '0;
      remaining_q <= '0;
      idx_q       <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      flits_sent  <= '0;
    end else begin
      out_valid <= send;
      if (send) begin
        out_data   <= flit_data;
        flits_sent <= flits_sent + CNT_WIDTH'(1);
      end
      case (state)
        ST_IDLE: begin
          if (req_val) begin
            hdr_q       <= build_header(req_chipid, req_x, req_y, req_fbits,
                                        req_len, req_msg_type, req_tag);
            seed_q      <= req_seed;
            remaining_q <= req_len;
            idx_q       <= '0;
            state       <= ST_HEAD;
          end
        end
        ST_HEAD: begin
          if (avail) begin
            state <= (remaining_q == 8'd0) ? ST_IDLE : ST_BODY;
          end
        end
        ST_BODY: begin
          if (avail) begin
            idx_q       <= idx_q + 8'd1;
            remaining_q <= remaining_q - 8'd1;
            if (remaining_q == 8'd1) begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef NOC_INJECT_TRACE_EN
  logic ovf_d;

  always @(negedge clk) begin
    if (out_valid) begin
      $display("%d: INJECT flit data: 0x%x", $time, out_data);
    end
    if (err_credit_ovf && !ovf_d) begin
      $display("%d : Simulation -> FAIL. noc_flit_injector: credit overflow", $time);
    end
    ovf_d <= err_credit_ovf;
  end
`else
`endif

endmodule

// File: tb/tb_noc_flit_injector.sv
// Scoreboard bench for noc_flit_injector: stimulus pushes expected flits,
// a negedge monitor pops and compares, and also models the router's credits.
module tb_noc_flit_injector;

  localparam int CREDITS = 4;

  logic        clk;
  logic        rst_n;
  logic        req_val;
  logic        req_rdy;
  logic [13:0] req_chipid;
  logic [7:0]  req_x;
  logic [7:0]  req_y;
  logic [3:0]  req_fbits;
  logic [7:0]  req_len;
  logic [7:0]  req_msg_type;
  logic [7:0]  req_tag;
  logic [63:0] req_seed;
  logic        out_valid;
  logic [63:0] out_data;
  logic        in_yummy;
  logic        busy;
  logic [31:0] flits_sent;
  logic        err_credit_ovf;

  noc_flit_injector #(.FLIT_WIDTH(64), .CREDITS(CREDITS), .CNT_WIDTH(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_val        (req_val),
    .req_rdy        (req_rdy),
    .req_chipid     (req_chipid),
    .req_x          (req_x),
    .req_y          (req_y),
    .req_fbits      (req_fbits),
    .req_len        (req_len),
    .req_msg_type   (req_msg_type),
    .req_tag        (req_tag),
    .req_seed       (req_seed),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .in_yummy       (in_yummy),
    .busy           (busy),
    .flits_sent     (flits_sent),
    .err_credit_ovf (err_credit_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic [63:0] exp_q[$];
  bit          head_q[$];
  int          exp_total = 0;
  int          acc_cyc = 0;
  int          seen = 0;
  int          outstanding = 0;
  bit          last_yummy = 0;
  int          head_cyc = 0;
  int          last_flit_cyc = 0;
  int          yummy_mode = 0;
  int          force_req = 0;
  int          force_done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Monitor plus router model: the router returns one credit per flit it holds.
  always @(negedge clk) begin
    if (!rst_n) begin
      in_yummy    = 1'b0;
      outstanding = 0;
      last_yummy  = 1'b0;
      force_done  = force_req;
    end else begin
      if (out_valid) begin
        checkOutput("credit_bound", 64'(outstanding + int'(last_yummy) < CREDITS), 64'd1);
        checkOutput("flit_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          checkOutput("flit_data", out_data, exp_q.pop_front());
          if (head_q.pop_front()) head_cyc = cyc;
        end
        seen++;
        outstanding++;
        last_flit_cyc = cyc;
      end
      last_yummy = 1'b0;
      if (force_req != force_done) begin
        force_done++;
        in_yummy = 1'b1;
        if (outstanding > 0) begin
          outstanding--;
          last_yummy = 1'b1;
        end
      end else if (outstanding > 0 &&
                   (yummy_mode == 2 || (yummy_mode == 1 && $urandom_range(0, 2) != 0))) begin
        in_yummy    = 1'b1;
        outstanding--;
        last_yummy  = 1'b1;
      end else begin
        in_yummy = 1'b0;
      end
    end
  end

  task automatic applyStimulus(input logic [13:0] chip, input logic [7:0] x,
                               input logic [7:0] y, input logic [3:0] fb,
                               input logic [7:0] len, input logic [7:0] msg,
                               input logic [7:0] tag, input logic [63:0] seed,
                               output int waited);
    @(negedge clk);
    req_chipid = chip; req_x = x; req_y = y; req_fbits = fb;
    req_len = len; req_msg_type = msg; req_tag = tag; req_seed = seed;
    req_val = 1'b1;
    waited = 0;
    while (!req_rdy && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
    if (!req_rdy) begin
      checkOutput("accept_timeout", 64'(waited), 64'd0);
      req_val = 1'b0;
      return;
    end
    exp_q.push_back({chip, x, y, fb, len, msg, tag, 6'b0});
    head_q.push_back(1'b1);
    for (int i = 0; i < int'(len); i++) begin
      exp_q.push_back(seed + 64'(i));
      head_q.push_back(1'b0);
    end
    exp_total += int'(len) + 1;
    acc_cyc = cyc + 1;
    @(negedge clk);
    req_val = 1'b0;
  endtask

  task automatic waitDrain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, "_drain"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    head_q.delete();
  endtask

  task automatic waitCreditsHome();
    int n = 0;
    while (outstanding != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("credits_home", 64'(outstanding), 64'd0);
  endtask

  task automatic checkResetState(input string name);
    checkOutput({name, "_out_valid"}, 64'(out_valid), 64'd0);
    checkOutput({name, "_out_data"}, out_data, 64'd0);
    checkOutput({name, "_req_rdy"}, 64'(req_rdy), 64'd1);
    checkOutput({name, "_busy"}, 64'(busy), 64'd0);
    checkOutput({name, "_flits_sent"}, 64'(flits_sent), 64'd0);
    checkOutput({name, "_err_ovf"}, 64'(err_credit_ovf), 64'd0);
  endtask

  initial begin
    int w;
    int s0;
    int c6;
    int n;
    rst_n = 1'b0; req_val = 1'b0;
    req_chipid = '0; req_x = '0; req_y = '0; req_fbits = '0;
    req_len = '0; req_msg_type = '0; req_tag = '0; req_seed = '0;
    #1;
    checkResetState("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] single packet, eager router");
    yummy_mode = 2;
    applyStimulus(14'd0, 8'd2, 8'd1, 4'd0, 8'd3, 8'h0E, 8'h05, 64'h100, w);
    waitDrain("single");
    checkOutput("single_hdr_latency", 64'(head_cyc - acc_cyc), 64'd1);
    checkOutput("single_back_to_back", 64'(last_flit_cyc - head_cyc), 64'd3);
    checkOutput("single_flits_sent", 64'(flits_sent), 64'(exp_total));
    checkOutput("single_req_rdy", 64'(req_rdy), 64'd1);

    $display("[TB] credit starvation");
    waitCreditsHome();
    yummy_mode = 0;
    s0 = seen;
    applyStimulus(14'h1234, 8'd7, 8'd9, 4'd3, 8'd7, 8'h22, 8'h33, 64'hABCD_0000_0000_0010, w);
    repeat (20) @(negedge clk);
    checkOutput("starve_count", 64'(seen - s0), 64'd4);
    checkOutput("starve_out_valid", 64'(out_valid), 64'd0);
    force_req++;
    repeat (6) @(negedge clk);
    checkOutput("starve_one_more", 64'(seen - s0), 64'd5);

    // Eager returns from here keep credits at one with send and yummy together.
    yummy_mode = 2;
    n = 0;
    while (seen - s0 < 6 && n < 100) begin
      @(negedge clk);
      n++;
    end
    c6 = last_flit_cyc;
    waitDrain("starve");
    checkOutput("sim_send_yummy_no_gap", 64'(last_flit_cyc - c6), 64'd2);

    $display("[TB] header-only packet then seed wrap");
    waitCreditsHome();
    applyStimulus(14'h3FFF, 8'hFF, 8'h00, 4'hF, 8'd0, 8'h01, 8'hEE, 64'h5, w);
    waitDrain("hdr_only");
    checkOutput("hdr_only_req_rdy", 64'(req_rdy), 64'd1);
    checkOutput("hdr_only_busy", 64'(busy), 64'd0);
    applyStimulus(14'd5, 8'd1, 8'd1, 4'd1, 8'd2, 8'h10, 8'h20, 64'hFFFF_FFFF_FFFF_FFFF, w);
    checkOutput("second_accept_wait", 64'(w), 64'd0);
    waitDrain("seed_wrap");

    $display("[TB] randomized packets");
    for (int p = 0; p < 30; p++) begin
      logic [7:0]  len;
      logic [63:0] seed;
      yummy_mode = ($urandom_range(0, 1) == 0) ? 1 : 2;
      len  = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(20, 60)) : 8'($urandom_range(0, 10));
      seed = ($urandom_range(0, 5) == 0) ? 64'hFFFF_FFFF_FFFF_FFF8 : {$urandom, $urandom};
      applyStimulus(14'($urandom), 8'($urandom), 8'($urandom), 4'($urandom), len,
                    8'($urandom), 8'($urandom), seed, w);
    end
    waitDrain("random");
    yummy_mode = 2;
    waitCreditsHome();
    checkOutput("random_flits_sent", 64'(flits_sent), 64'(exp_total));
    checkOutput("random_no_ovf", 64'(err_credit_ovf), 64'd0);

    $display("[TB] credit overflow");
    yummy_mode = 0;
    force_req++;
    repeat (3) @(negedge clk);
    checkOutput("ovf_set", 64'(err_credit_ovf), 64'd1);
    repeat (5) @(negedge clk);
    checkOutput("ovf_sticky", 64'(err_credit_ovf), 64'd1);

    $display("[TB] reset mid-body");
    yummy_mode = 2;
    s0 = seen;
    applyStimulus(14'd9, 8'd3, 8'd4, 4'd2, 8'd30, 8'h44, 8'h55, 64'h1000, w);
    n = 0;
    while (seen - s0 < 5 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("midbody_progress", 64'(seen - s0 >= 5), 64'd1);
    #2;
    rst_n = 1'b0;
    yummy_mode = 0;
    exp_q.delete();
    head_q.delete();
    exp_total = 0;
    #1;
    checkResetState("async_reset");
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b1;
    s0 = seen;
    repeat (30) @(negedge clk);
    checkOutput("post_reset_silent", 64'(seen - s0), 64'd0);
    checkOutput("post_reset_busy", 64'(busy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
